// File: rtl/usb2_ep_bufctl.sv
// usb2_ep_bufctl: ping-pong packet buffer for one USB2 endpoint,
// backed by a 1024x8 RAM split into two 512-byte halves.
module usb2_ep_bufctl (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   input  logic       in_last,
   input  logic       in_abort,
   output logic       in_ready,
   output logic       out_valid,
   output logic [7:0] out_data,
   output logic       out_last,
   input  logic       out_ready,
   output logic       ram_wr_we,
   output logic [9:0] ram_wr_adr,
   output logic [7:0] ram_wr_dat,
   output logic [9:0] ram_rd_adr,
   input  logic [7:0] ram_rd_dat,
   output logic [1:0] pkt_cnt,
   output logic       err_ovf
);

   typedef enum logic {IDLE, STREAM} rd_state_t;

   logic [1:0] full, full_nxt;
   logic [9:0] len0, len1, len_cur;
   logic       wr_sel, wr_sel_nxt;
   logic [9:0] wr_cnt, wr_cnt_nxt;
   logic       drop, drop_nxt;
   logic       rd_sel, rd_sel_nxt;
   logic [8:0] rd_idx, rd_idx_nxt;
   rd_state_t  state, state_nxt;

   logic accept;
   logic room;
   logic commit;
   logic ovf;
   logic hs;
   logic last_hs;

   assign in_ready   = ~full[wr_sel];
   assign accept     = in_valid & in_ready & ~in_abort;
   assign room       = ~wr_cnt[9];
   assign ram_wr_we  = accept & room & ~drop;
   assign ram_wr_adr = {wr_sel, wr_cnt[8:0]};
   assign ram_wr_dat = in_data;
   assign commit     = ram_wr_we & in_last;
   // a last byte that could not be stored closes an oversize packet
   assign ovf        = accept & in_last & ~ram_wr_we;

   always_comb begin
      wr_cnt_nxt = wr_cnt;
      drop_nxt   = drop;
      wr_sel_nxt = wr_sel;
      unique case (1'b1)
         in_abort: begin
            wr_cnt_nxt = '0;
            drop_nxt   = 1'b0;
         end
         accept & in_last: begin
            wr_cnt_nxt = '0;
            drop_nxt   = 1'b0;
            wr_sel_nxt = wr_sel ^ commit;
         end
         ram_wr_we & ~in_last: begin
            wr_cnt_nxt = wr_cnt + 10'd1;
         end
         accept & ~in_last & ~ram_wr_we: begin
            drop_nxt = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign len_cur    = rd_sel ? len1 : len0;
   assign out_valid  = (state == STREAM);
   assign out_last   = out_valid & ({1'b0, rd_idx} == len_cur - 10'd1);
   assign out_data   = ram_rd_dat;
   assign hs         = out_valid & out_ready;
   assign last_hs    = hs & out_last;
   assign rd_sel_nxt = rd_sel ^ last_hs;
   assign rd_idx_nxt = last_hs ? 9'd0 : rd_idx + 9'(hs);
   // the RAM answers one clock later, so present the next index now
   assign ram_rd_adr = {rd_sel_nxt, rd_idx_nxt};

   always_comb begin
      full_nxt = full;
      if (commit) begin
         full_nxt[wr_sel] = 1'b1;
      end
      if (last_hs) begin
         full_nxt[rd_sel] = 1'b0;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (full[rd_sel]) begin
               state_nxt = STREAM;
            end
         end
         STREAM: begin
            if (last_hs) begin
               state_nxt = full[~rd_sel] ? STREAM : IDLE;
            end
         end
      endcase
   end

   assign pkt_cnt = 2'(full[0]) + 2'(full[1]);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         full    <= '0;
         len0    <= '0;
         len1    <= '0;
         wr_sel  <= 1'b0;
         wr_cnt  <= '0;
         drop    <= 1'b0;
         rd_sel  <= 1'b0;
         rd_idx  <= '0;
         state   <= IDLE;
         err_ovf <= 1'b0;
      end else begin
         full    <= full_nxt;
         wr_sel  <= wr_sel_nxt;
         wr_cnt  <= wr_cnt_nxt;
         drop    <= drop_nxt;
         rd_sel  <= rd_sel_nxt;
         rd_idx  <= rd_idx_nxt;
         state   <= state_nxt;
         err_ovf <= ovf;
         if (commit & ~wr_sel) begin
            len0 <= wr_cnt + 10'd1;
         end
         if (commit & wr_sel) begin
            len1 <= wr_cnt + 10'd1;
         end
      end
   end

endmodule

// File: tb/tb_usb2_ep_bufctl.sv
// tb_usb2_ep_bufctl: packet-level reference model, RAM model,
// table of packet scenarios, directed corners and random traffic.
module tb_usb2_ep_bufctl;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'd0;
   logic       in_last = 1'b0;
   logic       in_abort = 1'b0;
   logic       in_ready;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_last;
   logic       out_ready = 1'b0;
   logic       ram_wr_we;
   logic [9:0] ram_wr_adr;
   logic [7:0] ram_wr_dat;
   logic [9:0] ram_rd_adr;
   logic [7:0] ram_rd_dat;
   logic [1:0] pkt_cnt;
   logic       err_ovf;

   usb2_ep_bufctl dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_data(in_data),
      .in_last(in_last), .in_abort(in_abort),
      .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data),
      .out_last(out_last), .out_ready(out_ready),
      .ram_wr_we(ram_wr_we), .ram_wr_adr(ram_wr_adr),
      .ram_wr_dat(ram_wr_dat), .ram_rd_adr(ram_rd_adr),
      .ram_rd_dat(ram_rd_dat),
      .pkt_cnt(pkt_cnt), .err_ovf(err_ovf)
   );

   always #5 clk = ~clk;

   logic [7:0] mem [0:1023];
   always @(posedge clk) begin
      if (ram_wr_we) mem[ram_wr_adr] <= ram_wr_dat;
      ram_rd_dat <= mem[ram_rd_adr];
   end

   typedef struct { logic [7:0] d; logic l; } ob_t;
   typedef struct {
      int len; int abort_at; int mode; int exp_dlv; int exp_ovf;
   } vec_t;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   ob_t exp_q[$];
   int n_chk = 0, n_pass = 0;
   int delivered = 0, ovf_seen = 0, wr_seen = 0;
   int n_commit = 0, commit_cyc = -100, free_cyc = -100;
   int exp_cnt = 0, mode = 1, last_acc_cyc = 0;
   int exp_dlv_total = 0, exp_ovf_total = 0;

   function automatic void chk(input string nm, input int act,
                               input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endfunction

   task automatic summary();
      $display("%0d/%0d checks passed", n_pass, n_chk);
   endtask

   task automatic timeout(input string nm);
      n_chk++;
      $display("FAIL %s: timeout, got none expected event", nm);
      summary();
      $finish;
   endtask

   initial begin
      #1500000;
      timeout("watchdog");
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (mode)
            0: out_ready = 1'b0;
            1: out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // consumer side: byte order, stall stability, occupancy model
   initial begin
      ob_t e;
      logic stalled;
      logic [7:0] hold_d;
      logic hold_l;
      stalled = 1'b0;
      hold_d = 8'd0;
      hold_l = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            stalled = 1'b0;
            exp_cnt = 0;
            free_cyc = -100;
         end else begin
            if (commit_cyc == cyc - 1) exp_cnt++;
            if (free_cyc == cyc - 1) exp_cnt--;
            chk("pkt_cnt", int'(pkt_cnt), exp_cnt);
            chk("in_ready", int'(in_ready), int'(exp_cnt != 2));
            if (stalled) begin
               chk("stall_valid", int'(out_valid), 1);
               chk("stall_data", int'(out_data), int'(hold_d));
               chk("stall_last", int'(out_last), int'(hold_l));
            end
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_byte", int'(out_data), -1);
               end else begin
                  e = exp_q.pop_front();
                  chk("out_data", int'(out_data), int'(e.d));
                  chk("out_last", int'(out_last), int'(e.l));
               end
               if (out_last) begin
                  delivered++;
                  free_cyc = cyc;
               end
            end
            stalled = out_valid && !out_ready;
            hold_d = out_data;
            hold_l = out_last;
            if (err_ovf) ovf_seen++;
            if (ram_wr_we) wr_seen++;
         end
      end
   end

   task automatic wait_ready();
      int n;
      n = 0;
      @(negedge clk);
      while (!in_ready) begin
         n++;
         if (n > 6000) timeout("in_ready");
         @(negedge clk);
      end
   endtask

   // send one packet; the model decides commit / overflow / discard
   task automatic send_pkt(input int len, input int abort_at,
                           input bit gaps, input logic [7:0] base);
      ob_t bytes[$];
      ob_t b;
      logic [7:0] d;
      for (int i = 0; i < len; i++) begin
         if (i == abort_at) begin
            in_abort = 1'b1;
            in_valid = 1'($urandom_range(0, 1));
            in_data = 8'($urandom);
            in_last = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("abort_no_write", int'(ram_wr_we), 0);
            @(posedge clk);
            #1;
            in_abort = 1'b0;
            in_valid = 1'b0;
            in_last = 1'b0;
            return;
         end
         if (gaps && $urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
         d = base + 8'(i);
         in_valid = 1'b1;
         in_data = d;
         in_last = (i == len - 1);
         wait_ready();
         chk("wr_we", int'(ram_wr_we), int'(i < 512));
         if (i < 512) begin
            chk("wr_adr", int'(ram_wr_adr),
                int'({n_commit[0], i[8:0]}));
            chk("wr_dat", int'(ram_wr_dat), int'(d));
         end
         if (i == len - 1) begin
            last_acc_cyc = cyc;
            if (len <= 512) commit_cyc = cyc;
         end
         b.d = d;
         b.l = (i == len - 1);
         bytes.push_back(b);
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         in_last = 1'b0;
      end
      if (len <= 512) begin
         n_commit++;
         exp_dlv_total++;
         foreach (bytes[j]) exp_q.push_back(bytes[j]);
      end else begin
         exp_ovf_total++;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      @(negedge clk);
      while (exp_q.size() != 0 || out_valid || pkt_cnt != 0) begin
         n++;
         if (n > 8000) timeout("drain");
         @(negedge clk);
      end
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   // asserted mid-cycle so the clear must be asynchronous
   task automatic do_reset();
      @(negedge clk);
      #2;
      reset_n = 1'b0;
      in_valid = 1'b0;
      in_abort = 1'b0;
      in_last = 1'b0;
      exp_q.delete();
      n_commit = 0;
      commit_cyc = -100;
      #1;
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_last", int'(out_last), 0);
      chk("rst_wr_we", int'(ram_wr_we), 0);
      chk("rst_rd_adr", int'(ram_rd_adr), 0);
      chk("rst_pkt_cnt", int'(pkt_cnt), 0);
      chk("rst_err_ovf", int'(err_ovf), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   vec_t tbl [8];

   initial begin
      int d0, o0, w0, e0, eo0, n, run, len, ab, r;
      bit chk_rdy;
      tbl[0] = '{1,   -1, 1, 1, 0};
      tbl[1] = '{512, -1, 2, 1, 0};
      tbl[2] = '{513, -1, 1, 0, 1};
      tbl[3] = '{700, -1, 2, 0, 1};
      tbl[4] = '{10,   5, 1, 0, 0};
      tbl[5] = '{100, -1, 2, 1, 0};
      tbl[6] = '{100, -1, 2, 1, 0};
      tbl[7] = '{2,   -1, 2, 1, 0};

      do_reset();

      // four bytes A0..A3, two-cycle latency, pkt_cnt 1 -> 0
      mode = 1;
      d0 = delivered;
      send_pkt(4, -1, 0, 8'hA0);
      @(negedge clk);
      chk("lat_t1_valid", int'(out_valid), 0);
      chk("lat_t1_pkt_cnt", int'(pkt_cnt), 1);
      @(negedge clk);
      chk("lat_t2_cycle", cyc - last_acc_cyc, 2);
      chk("lat_t2_valid", int'(out_valid), 1);
      chk("first_byte", int'(out_data), 'hA0);
      @(posedge clk);
      #1;
      drain();
      chk("short_pkt_count", delivered - d0, 1);

      // two full halves block the writer, then drain back-to-back
      do_reset();
      mode = 0;
      send_pkt(512, -1, 0, 8'h10);
      send_pkt(512, -1, 0, 8'h55);
      @(negedge clk);
      chk("both_full_cnt", int'(pkt_cnt), 2);
      chk("both_full_rdy", int'(in_ready), 0);
      @(posedge clk);
      #1;
      fork
         send_pkt(512, -1, 0, 8'hC3);
         begin
            mode = 1;
            n = 0;
            run = 0;
            chk_rdy = 1'b0;
            @(negedge clk);
            while (!(out_valid && out_ready)) begin
               n++;
               if (n > 20) timeout("stream_start");
               @(negedge clk);
            end
            for (int j = 0; j < 1024; j++) begin
               if (chk_rdy) begin
                  chk("rdy_after_free", int'(in_ready), 1);
                  chk_rdy = 1'b0;
               end
               if (out_valid && out_ready) run++;
               if (j == 511) begin
                  chk("first_pkt_last", int'(out_last), 1);
                  chk_rdy = 1'b1;
               end
               @(negedge clk);
            end
            chk("contiguous_1024", run, 1024);
            @(posedge clk);
            #1;
         end
      join
      drain();

      // oversize packet dropped, next packet in half 0
      do_reset();
      mode = 1;
      d0 = delivered;
      o0 = ovf_seen;
      w0 = wr_seen;
      send_pkt(513, -1, 0, 8'h20);
      @(negedge clk);
      chk("ovf_pulse", int'(err_ovf), 1);
      chk("ovf_pkt_cnt", int'(pkt_cnt), 0);
      @(negedge clk);
      chk("ovf_pulse_end", int'(err_ovf), 0);
      @(posedge clk);
      #1;
      send_pkt(2, -1, 0, 8'hE0);
      drain();
      chk("ovf_count", ovf_seen - o0, 1);
      chk("ovf_next_dlv", delivered - d0, 1);
      chk("ovf_writes", wr_seen - w0, 514);

      // abort after 10 bytes, 3-byte packet lands at 0..2
      do_reset();
      d0 = delivered;
      send_pkt(20, 10, 0, 8'h30);
      send_pkt(3, -1, 0, 8'h90);
      drain();
      chk("abort_dlv", delivered - d0, 1);

      // reset while streaming
      do_reset();
      mode = 0;
      send_pkt(5, -1, 0, 8'h77);
      n = 0;
      @(negedge clk);
      while (!out_valid) begin
         n++;
         if (n > 20) timeout("mid_stream");
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      chk("mid_stream_valid", int'(out_valid), 1);
      do_reset();
      mode = 1;

      foreach (tbl[i]) begin
         d0 = delivered;
         o0 = ovf_seen;
         mode = tbl[i].mode;
         send_pkt(tbl[i].len, tbl[i].abort_at, tbl[i].mode == 2,
                  8'(i * 37));
         drain();
         chk($sformatf("tbl%0d_dlv", i), delivered - d0,
             tbl[i].exp_dlv);
         chk($sformatf("tbl%0d_ovf", i), ovf_seen - o0,
             tbl[i].exp_ovf);
      end

      d0 = delivered;
      o0 = ovf_seen;
      e0 = exp_dlv_total;
      eo0 = exp_ovf_total;
      for (int p = 0; p < 40; p++) begin
         r = $urandom_range(0, 99);
         if (r < 15) len = $urandom_range(1, 4);
         else if (r < 85) len = $urandom_range(5, 200);
         else len = $urandom_range(505, 530);
         if ($urandom_range(0, 9) == 0) ab = $urandom_range(0, len);
         else ab = -1;
         mode = $urandom_range(1, 2);
         send_pkt(len, ab, 1, 8'($urandom));
      end
      drain();
      chk("rnd_dlv", delivered - d0, exp_dlv_total - e0);
      chk("rnd_ovf", ovf_seen - o0, exp_ovf_total - eo0);

      summary();
      $finish;
   end

endmodule
